reg_file: RTL and testbench
===========================

# reg_file

Parametrised multi-port register file, the next generation of the single enabled `register`: DEPTH words of WIDTH bits with one synchronous write port and two asynchronous read ports. It adds asynchronous reset, byte-lane write masking, an optional hardwired-zero entry 0, and optional same-cycle write-to-read bypass. It is the architectural register store for the single-cycle and pipelined datapath labs, sitting between decode (read addresses) and writeback (write port).

## Interface
- `WIDTH`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 32: number of entries; power of two, at least 2.
- `AW`, $clog2(DEPTH): address width; derived, never overridden.
- `ZERO_REG`, 1: when 1, entry 0 always reads 0 and ignores writes.
- `BYPASS`, 1: when 1, a read of the address being written this cycle returns the merged new data.
- `RESET_VAL`, 0: value loaded into every entry on reset.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `we`, input, 1: write enable.
- `wa`, input, AW: write address.
- `wd`, input, WIDTH: write data.
- `wbe`, input, WIDTH/8: byte-lane write enables; bit i covers `wd[8i+7:8i]`.
- `ra1`, input, AW: read address, port 1.
- `rd1`, output, WIDTH: read data, port 1.
- `ra2`, input, AW: read address, port 2.
- `rd2`, output, WIDTH: read data, port 2.

## Operation
- Storage: DEPTH × WIDTH flops; no RAM macros.
- Write:
  - On the rising edge of `clk` with `we`=1 and `rst_n`=1, each byte lane i of entry `wa` with `wbe[i]`=1 takes `wd` lane i.
  - Lanes with `wbe[i]`=0 hold their value.
  - `we`=1 with `wbe`=0 is a legal no-op.
- Read: `rdN` = entry[`raN`] combinationally. Both ports are independent and may use the same address.
- Zero register: when `ZERO_REG`=1, reads of address 0 return 0 on both ports, with or without bypass. Writes to address 0 are dropped; the flops for entry 0 may be omitted.
- Bypass:
  - Applies when `BYPASS`=1, `we`=1, `rst_n`=1 and `raN`==`wa`, excluding address 0 under `ZERO_REG`.
  - `rdN` then returns the post-write word: lanes with `wbe` set from `wd`, all other lanes from the current entry.
  - When `BYPASS`=0, the old value is read until the edge.
- Reset:
  - `rst_n`=0 immediately, without waiting for `clk`, sets every entry to `RESET_VAL`, except entry 0 when `ZERO_REG`=1.
  - Writes and bypass are suppressed while `rst_n`=0.
  - Reset asserted mid-write (before the edge) discards that write.

## Timing
- Write latency: 1 cycle. The value is visible on a non-bypassed read after the rising edge.
- Read latency: 0 cycles (combinational from `raN`, and from `wd`/`wbe`/`we` when bypassing).
- Reset values: `rd1` = `rd2` = `RESET_VAL` (0 for address 0 when `ZERO_REG`=1) within the same delta as `rst_n` falling.
- Reset release: the first write takes effect on the first rising edge at which `rst_n`=1 is sampled. Deassertion coincident with an edge must not write; the bench must keep `rst_n` deassertion at least 1 ns clear of `clk` rising.
- Out-of-range address: not possible, because DEPTH is a power of two and the address wraps naturally in AW bits.
- Simultaneous events:
  - Both read ports on `wa` with bypass: both see the new data.
  - Read port on `wa` without bypass: sees the old data this cycle and the new data next cycle.

## Structure
- Shared package `rf_pkg`: default WIDTH/DEPTH constants, the `BYTES = WIDTH/8` expression, and the byte-merge helper function (old word, new word, mask → merged word), which is used by both the write path and the bypass path.
- Sub-module `rf_word`: one WIDTH-bit entry with async active-low reset to `RESET_VAL` and per-byte enables. It is instantiated DEPTH times (DEPTH−1 times under `ZERO_REG`) by a generate loop.
- Read muxes and bypass compare live in `reg_file` itself.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle with `RESET_VAL`=32'hA5A5A5A5 and `ZERO_REG`=1 → `rd1` at address 5 = A5A5A5A5 at once (no clock edge) and `rd2` at address 0 = 0.
- Full write: write 32'hDEADBEEF to address 7 with `wbe`=4'hF; next cycle set `ra1`=7 and `ra2`=7 → both read DEADBEEF.
- Byte mask: entry 3 = 12345678, then write FFFFFFFF with `wbe`=4'b0101 → entry 3 = 12FF56FF.
- Zero register: write 32'hCAFEF00D to address 0 → `rd1` at address 0 stays 0. Rerun with `ZERO_REG`=0 → reads CAFEF00D after the edge.
- Bypass: entry 9 = 0 and `BYPASS`=1; in the same cycle set `we`=1, `wa`=9, `wd`=32'h11223344, `wbe`=4'b0011, `ra1`=9 → `rd1`=00003344 before the edge. With `BYPASS`=0 → `rd1`=0 before the edge and 00003344 after it.
- Reset mid-write: set `we`=1, `wa`=4, `wd`=32'h55, then pull `rst_n` low 2 ns before the edge and release after it → entry 4 = `RESET_VAL`, and the next edge with `rst_n`=1 writes normally.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and the byte-merge helper used by both the register write
// path and the same-cycle bypass path of reg_file.
package rf_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

  // Widest word the merge helper handles; callers cast in and out of this size.
  localparam int RF_MAX_W = 1024;
  localparam int RF_MAX_B = RF_MAX_W / 8;

  function automatic int rf_bytes(input int width);
    return width / 8;
  endfunction

  function automatic logic [RF_MAX_W-1:0] byte_merge(
    input logic [RF_MAX_W-1:0] old_w,
    input logic [RF_MAX_W-1:0] new_w,
    input logic [RF_MAX_B-1:0] mask
  );
    logic [RF_MAX_W-1:0] res;
    for (int i = 0; i < RF_MAX_B; i++) begin
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rf_word.sv
// One register-file entry: WIDTH flops, async active-low reset to RESET_VAL,
// per-byte write enables merged through the shared helper.
module rf_word
  import rf_pkg::*;
#(
  parameter int              WIDTH     = RF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH/8-1:0] be,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] nxt;

  assign nxt = WIDTH'(byte_merge(RF_MAX_W'(q), RF_MAX_W'(d), RF_MAX_B'(be)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (|be) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: DEPTH x WIDTH flops, one byte-masked synchronous write port,
// two combinational read ports with optional zero entry and write bypass.
module reg_file
  import rf_pkg::*;
#(
  parameter int               WIDTH     = RF_WIDTH,
  parameter int               DEPTH     = RF_DEPTH,
  parameter int               AW        = $clog2(DEPTH),
  parameter bit               ZERO_REG  = 1'b1,
  parameter bit               BYPASS    = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic [WIDTH-1:0]   wd,
  input  logic [WIDTH/8-1:0] wbe,
  input  logic [AW-1:0]      ra1,
  output logic [WIDTH-1:0]   rd1,
  input  logic [AW-1:0]      ra2,
  output logic [WIDTH-1:0]   rd2
);

  localparam int BYTES = rf_bytes(WIDTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wmerge;
  logic             zero1, zero2;
  logic             byp1, byp2;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if (ZERO_REG && i == 0) begin : g_zero
      // No storage for entry 0: writes to it simply have nowhere to land.
      assign mem[i] = '0;
    end else begin : g_flop
      logic [BYTES-1:0] be;
      assign be = (we && wa == AW'(i)) ? wbe : '0;
      rf_word #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RESET_VAL)
      ) u_word (
        .clk  (clk),
        .rst_n(rst_n),
        .be   (be),
        .d    (wd),
        .q    (mem[i])
      );
    end
  end

  // Post-write view of the entry being written, for the bypass path.
  assign wmerge = WIDTH'(byte_merge(RF_MAX_W'(mem[wa]), RF_MAX_W'(wd), RF_MAX_B'(wbe)));

  assign zero1 = ZERO_REG && (ra1 == '0);
  assign zero2 = ZERO_REG && (ra2 == '0);
  assign byp1  = BYPASS && we && rst_n && (ra1 == wa);
  assign byp2  = BYPASS && we && rst_n && (ra2 == wa);

  assign rd1 = zero1 ? '0 : (byp1 ? wmerge : mem[ra1]);
  assign rd2 = zero2 ? '0 : (byp2 ? wmerge : mem[ra2]);

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: two instances (zero-reg + bypass, and plain) share the
// stimulus; a reference model feeds an expected queue compared per scenario.
module tb_reg_file;

  localparam logic [31:0] RV_A = 32'hA5A5A5A5;
  localparam logic [31:0] RV_B = 32'h00000000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        we    = 1'b0;
  logic [4:0]  wa    = '0;
  logic [31:0] wd    = '0;
  logic [3:0]  wbe   = '0;
  logic [4:0]  ra1   = 5'd5;
  logic [4:0]  ra2   = 5'd0;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;

  logic [31:0] model_a [32];
  logic [31:0] model_b [32];

  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  string       tag_q [$];

  int n_vec = 0;
  int n_err = 0;

  reg_file #(
    .WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VAL(RV_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra1(ra1), .rd1(a_rd1), .ra2(ra2), .rd2(a_rd2)
  );

  reg_file #(
    .WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0), .RESET_VAL(RV_B)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .ra1(ra1), .rd1(b_rd1), .ra2(ra2), .rd2(b_rd2)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      model_a[i] = (i == 0) ? 32'h0 : RV_A;
      model_b[i] = RV_B;
    end
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a != 5'd0) model_a[a] = merge32(model_a[a], d, be);
    model_b[a] = merge32(model_b[a], d, be);
  endtask

  // Driver: one full write cycle, model updated at the edge.
  task automatic write_word(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d; wbe = be;
    @(posedge clk);
    model_write(a, d, be);
    #1 we = 1'b0;
  endtask

  // Scoreboard push: expected values plus the outputs observed right now.
  task automatic snap(input string tag, input logic [31:0] ea1, input logic [31:0] ea2,
                      input logic [31:0] eb1, input logic [31:0] eb2);
    exp_q.push_back(ea1); obs_q.push_back(a_rd1); tag_q.push_back({tag, "/a.rd1"});
    exp_q.push_back(ea2); obs_q.push_back(a_rd2); tag_q.push_back({tag, "/a.rd2"});
    exp_q.push_back(eb1); obs_q.push_back(b_rd1); tag_q.push_back({tag, "/b.rd1"});
    exp_q.push_back(eb2); obs_q.push_back(b_rd2); tag_q.push_back({tag, "/b.rd2"});
  endtask

  task automatic test_reset();
    logic [31:0] e, o;
    string t;
    #2 rst_n = 1'b0;
    model_reset();
    #1 snap("reset_async", RV_A, 32'h0, RV_B, RV_B);
    ra1 = 5'd31; ra2 = 5'd17;
    #1 snap("reset_hi_addr", RV_A, RV_A, RV_B, RV_B);
    @(negedge clk);
    rst_n = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_full_write();
    logic [31:0] e, o;
    string t;
    write_word(5'd7, 32'hDEADBEEF, 4'hF);
    ra1 = 5'd7; ra2 = 5'd7;
    #1 snap("full_write", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_byte_mask();
    logic [31:0] e, o;
    string t;
    write_word(5'd3, 32'h12345678, 4'hF);
    write_word(5'd3, 32'hFFFFFFFF, 4'b0101);
    ra1 = 5'd3; ra2 = 5'd3;
    #1 snap("byte_mask", 32'h12FF56FF, 32'h12FF56FF, 32'h12FF56FF, 32'h12FF56FF);
    write_word(5'd3, 32'h00000000, 4'h0);
    #1 snap("mask_none", 32'h12FF56FF, 32'h12FF56FF, 32'h12FF56FF, 32'h12FF56FF);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] e, o;
    string t;
    write_word(5'd0, 32'hCAFEF00D, 4'hF);
    ra1 = 5'd0; ra2 = 5'd0;
    #1 snap("zero_reg", 32'h0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e, o;
    string t;
    write_word(5'd9, 32'h0, 4'hF);
    @(negedge clk);
    we = 1'b1; wa = 5'd9; wd = 32'h11223344; wbe = 4'b0011; ra1 = 5'd9; ra2 = 5'd9;
    #1 snap("bypass_pre", 32'h00003344, 32'h00003344, 32'h0, 32'h0);
    @(posedge clk);
    model_write(5'd9, 32'h11223344, 4'b0011);
    #1 we = 1'b0;
    #1 snap("bypass_post", 32'h00003344, 32'h00003344, 32'h00003344, 32'h00003344);
    // Writing address 0 must not bypass onto the zero entry.
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; wbe = 4'hF; ra1 = 5'd0; ra2 = 5'd5;
    #1 snap("bypass_zero", 32'h0, RV_A, 32'hCAFEF00D, RV_B);
    @(posedge clk);
    model_write(5'd0, 32'hFFFFFFFF, 4'hF);
    #1 we = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] e, o;
    string t;
    @(negedge clk);
    we = 1'b1; wa = 5'd4; wd = 32'h55; wbe = 4'hF; ra1 = 5'd4; ra2 = 5'd3;
    #3 rst_n = 1'b0;
    model_reset();
    #1 snap("rst_during_write", RV_A, RV_A, RV_B, RV_B);
    @(posedge clk);
    #3 rst_n = 1'b1; we = 1'b0;
    #1 snap("rst_after_release", RV_A, RV_A, RV_B, RV_B);
    @(negedge clk);
    we = 1'b1;
    @(posedge clk);
    model_write(5'd4, 32'h55, 4'hF);
    #1 we = 1'b0;
    #1 snap("rst_next_write", 32'h55, RV_A, 32'h55, RV_B);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e, o, ea1, ea2;
    string t;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      we  = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      wbe = 4'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      #1;
      ea1 = (ra1 == 5'd0) ? 32'h0 :
            (we && ra1 == wa) ? merge32(model_a[wa], wd, wbe) : model_a[ra1];
      ea2 = (ra2 == 5'd0) ? 32'h0 :
            (we && ra2 == wa) ? merge32(model_a[wa], wd, wbe) : model_a[ra2];
      snap($sformatf("random%0d", n), ea1, ea2, model_b[ra1], model_b[ra2]);
      @(posedge clk);
      if (we) model_write(wa, wd, wbe);
      #1 we = 1'b0;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", t, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_mask();
    test_zero_reg();
    test_bypass();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
